alu_req_arbiter: RTL

- Shares one ALU32Bit instance between two requesters.
- Does round-robin arbitration, latches operands and drives the ALU from registers.
- Captures result/cout one cycle later and returns a response to the granted requester.
- Sits between requesters and the ALU; the ALU stays combinational and outside this block.

---
 rtl/alu_req_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// Purpose : shares one external combinational ALU between two requesters using round-robin grant.
// Latency : request accepted at edge N, response valid from edge N+1 (handshake sampled at N+2); 1 op / 3 cycles peak.
// Backpressure: req_ready only in IDLE; a response is held stable until rsp_ready[owner], non-owner rsp_ready ignored.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready [1:0]  per-requester request handshake
//   req_a*/req_b*/req_op*      operands and op code of requester 0 / 1
//   rsp_valid/rsp_ready [1:0]  per-requester response handshake (rsp_valid one-hot or zero)
//   rsp_result/cout/err        shared response payload (err = illegal op code)
//   alu_a/alu_b/alu_op/alu_cin registered drive to the external ALU
//   alu_result/alu_cout        combinational return from the external ALU
//   grant_cnt0/grant_cnt1      16-bit wrapping accept counters, present only with ALU_ARB_COUNT_EN defined
module alu_req_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_b1,
  input  logic [2:0]   req_op0,
  input  logic [2:0]   req_op1,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_cout,
  output logic         rsp_err,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic         alu_cin,
  input  logic [W-1:0] alu_result,
  input  logic         alu_cout
`ifdef ALU_ARB_COUNT_EN
  ,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic         last_grant_q;
  logic         owner_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [2:0]   op_q;
  logic [W-1:0] res_q;
  logic         cout_q;
  logic         err_q;
  logic         grant;
  logic         accept;
  logic         op_legal;

  // Round-robin pick: a lone requester always wins; on a tie the one
  // that was not served last goes next.
  always_comb begin
    grant = 1'b0;
    unique case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    op_legal = 1'b0;
    unique case (op_q)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  end

  // req_ready is already gated by reset below, so accept is too.
  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant ? 2'b10 : 2'b01;
          state_d   = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshakes are suppressed while reset is held so nothing transfers
    // on the edge that clears the state.
    if (reset) begin
      req_ready = 2'b00;
      rsp_valid = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      res_q        <= '0;
      cout_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q          <= grant ? req_a1 : req_a0;
        b_q          <= grant ? req_b1 : req_b0;
        op_q         <= grant ? req_op1 : req_op0;
        owner_q      <= grant;
        last_grant_q <= grant;
      end
      if (state_q == EXEC) begin
        // Illegal op codes never sample the ALU; the response is a clean error.
        if (op_legal) begin
          res_q  <= alu_result;
          cout_q <= alu_cout;
          err_q  <= 1'b0;
        end else begin
          res_q  <= '0;
          cout_q <= 1'b0;
          err_q  <= 1'b1;
        end
      end
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  // SUB and LESS are the only legal ops with op[2] set and both need cin=1.
  assign alu_cin    = op_q[2];
  assign rsp_result = res_q;
  assign rsp_cout   = cout_q;
  assign rsp_err    = err_q;

`ifdef ALU_ARB_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (req_ready[0]) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req_ready[1]) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule
